mux16_rr_arbiter: RTL and testbench



---
 rtl/mux16_rr_arbiter_pkg.sv | 18 +
 rtl/mux16_rr_arbiter_if.sv | 24 ++
 rtl/mux16_rr_pick.sv | 30 +++
 rtl/mux16_rr_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mux16_rr_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared types and constants for the 16-requester round-robin mux arbiter.
package mux16_arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;
  localparam int HOLD_W  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // One-hot grant vector for a binary requester index.
  function automatic logic [NUM_REQ-1:0] onehot_of(input logic [SEL_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Request/data/grant bundle between the requesting bit-lanes (master) and the
// arbiter that owns the shared mux (slave).
interface mux16_rr_arbiter_if;
  import mux16_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] din;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               dout;
  logic               dout_vld;
  logic               busy;

  modport master (
    output req, din,
    input  gnt, sel, dout, dout_vld, busy
  );

  modport slave (
    input  req, din,
    output gnt, sel, dout, dout_vld, busy
  );

endinterface

// File: rtl/mux16_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after i_start,
// wrapping modulo 16. o_found is low when no request is set.
module mux16_rr_pick
  import mux16_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_start,
  output logic               o_found,
  output logic [SEL_W-1:0]   o_idx
);

  logic [NUM_REQ-1:0] w_rot;
  logic [SEL_W-1:0]   w_ofs;

  // Rotate the request vector so the search start sits at bit 0.
  always_comb begin
    w_rot = NUM_REQ'({i_req, i_req} >> i_start);
  end

  // Lowest set bit of the rotated vector is the winner; map back by adding start.
  always_comb begin
    w_ofs = {SEL_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_ofs = w_rot[i] ? SEL_W'(i) : w_ofs;
    end
    o_found = |w_rot;
    o_idx   = i_start + w_ofs;
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 16:1 single-bit mux.
// Optional macro MUX16_ARB_HOLD_LIMIT_EN adds a hold counter that forces the
// owner to release after HOLD_MAX consecutive grant cycles.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux16_rr_arbiter_if.slave io_bus
);

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
      $error("HOLD_MAX must be within 1..255");
    end
  endgenerate

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               r_dout;
  logic               w_dout_nxt;
  logic               r_dout_vld;
  logic               w_dout_vld_nxt;
  logic               r_busy;
  logic               w_busy_nxt;

  logic [SEL_W-1:0]   w_start;
  logic               w_found;
  logic [SEL_W-1:0]   w_idx;
  logic               w_release;

  // One picker serves both IDLE arbitration (from ptr) and release
  // re-arbitration (from the slot after the departing owner).
  always_comb begin
    if (r_state == GRANT) begin
      w_start = r_sel + 4'd1;
    end else begin
      w_start = r_ptr;
    end
  end

  mux16_rr_pick u_pick (
    .i_req   (io_bus.req),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

`ifdef MUX16_ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              w_load;

  // Owner gives up the grant when it drops req or has used its full slot.
  always_comb begin
    w_release = ~io_bus.req[r_sel] | (r_hold_cnt == HOLD_LAST);
  end

  // A new grant is loaded from IDLE or on a handoff with a winner.
  always_comb begin
    w_load = w_found & ((r_state == IDLE) | ((r_state == GRANT) & w_release));
  end

  // Hold counter: cleared on every new grant, saturating count while granted.
  always_comb begin
    if (w_load) begin
      w_hold_cnt_nxt = {HOLD_W{1'b0}};
    end else if ((r_state == GRANT) && (r_hold_cnt != 8'hFF)) begin
      w_hold_cnt_nxt = r_hold_cnt + 8'd1;
    end else begin
      w_hold_cnt_nxt = r_hold_cnt;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= {HOLD_W{1'b0}};
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end
`else
  // Without the hold limit the owner keeps the grant until it drops req.
  always_comb begin
    w_release = ~io_bus.req[r_sel];
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave IDLE on any request, leave GRANT only when a
  // release finds no other requester.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (w_release && !w_found) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GRANT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and the round-robin pointer.
  always_comb begin
    w_gnt_nxt      = r_gnt;
    w_sel_nxt      = r_sel;
    w_dout_nxt     = r_dout;
    w_dout_vld_nxt = r_dout_vld;
    w_busy_nxt     = r_busy;
    w_ptr_nxt      = r_ptr;
    case (r_state)
      IDLE: begin
        w_dout_vld_nxt = 1'b0;
        if (w_found) begin
          w_gnt_nxt  = onehot_of(w_idx);
          w_sel_nxt  = w_idx;
          w_busy_nxt = 1'b1;
        end else begin
          w_gnt_nxt  = {NUM_REQ{1'b0}};
          w_busy_nxt = 1'b0;
        end
      end
      GRANT: begin
        w_dout_nxt     = io_bus.din[r_sel];
        w_dout_vld_nxt = 1'b1;
        if (w_release) begin
          // Departing owner becomes lowest priority.
          w_ptr_nxt = r_sel + 4'd1;
          if (w_found) begin
            w_gnt_nxt  = onehot_of(w_idx);
            w_sel_nxt  = w_idx;
            w_busy_nxt = 1'b1;
          end else begin
            w_gnt_nxt  = {NUM_REQ{1'b0}};
            w_busy_nxt = 1'b0;
          end
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_gnt_nxt      = {NUM_REQ{1'b0}};
        w_sel_nxt      = {SEL_W{1'b0}};
        w_dout_vld_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_ptr_nxt      = {SEL_W{1'b0}};
      end
    endcase
  end

  // Output and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= {NUM_REQ{1'b0}};
      r_sel      <= {SEL_W{1'b0}};
      r_dout     <= 1'b0;
      r_dout_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_ptr      <= {SEL_W{1'b0}};
    end else begin
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_dout     <= w_dout_nxt;
      r_dout_vld <= w_dout_vld_nxt;
      r_busy     <= w_busy_nxt;
      r_ptr      <= w_ptr_nxt;
    end
  end

  assign io_bus.gnt      = r_gnt;
  assign io_bus.sel      = r_sel;
  assign io_bus.dout     = r_dout;
  assign io_bus.dout_vld = r_dout_vld;
  assign io_bus.busy     = r_busy;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: a behavioural model predicts the
// outputs after every clock edge, a monitor compares on the falling edge.
module tb_mux16_rr_arbiter;

  localparam int HOLD_MAX = 4;
`ifdef MUX16_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        dout;
    logic        vld;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mux16_rr_arbiter_if bus ();

  mux16_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Model state: owner index (-1 when idle), priority pointer, cycles held.
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_held = 0;
  int         m_win;
  logic [3:0] m_sel = 4'd0;
  logic       m_dout = 1'b0;
  logic       m_vld = 1'b0;
  exp_t       m_e;

  function automatic int search(input logic [15:0] r, input int start);
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  // Reference model, advanced once per rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_held = 0;
      m_sel = 4'd0; m_dout = 1'b0; m_vld = 1'b0;
    end else begin
      if (m_owner < 0) begin
        m_vld = 1'b0;
        m_win = search(bus.req, m_ptr);
        if (m_win >= 0) begin
          m_owner = m_win;
          m_held  = 0;
        end
      end else begin
        m_dout = bus.din[m_owner];
        m_vld  = 1'b1;
        m_held = m_held + 1;
        if (!bus.req[m_owner] || (HOLD_EN && m_held == HOLD_MAX)) begin
          m_ptr   = (m_owner + 1) % 16;
          m_owner = search(bus.req, m_ptr);
          m_held  = 0;
        end
      end
      if (m_owner >= 0) m_sel = 4'(m_owner);
      m_e.gnt  = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
      m_e.sel  = m_sel;
      m_e.dout = m_dout;
      m_e.vld  = m_vld;
      m_e.busy = (m_owner >= 0);
      exp_q.push_back(m_e);
    end
  end

  // Monitor: compare DUT outputs against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.gnt, bus.sel, bus.dout, bus.dout_vld, bus.busy};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle t=%0t got gnt=%h sel=%0d dout=%b vld=%b busy=%b expected gnt=%h sel=%0d dout=%b vld=%b busy=%b",
                 $time, a.gnt, a.sel, a.dout, a.vld, a.busy, e.gnt, e.sel, e.dout, e.vld, e.busy);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] r, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.req = r;
      bus.din = 16'($urandom);
    end
  endtask

  initial begin
    int         vld_cnt;
    int         hold_cnt;
    logic [15:0] prev_gnt;
    logic [15:0] r;

    // Reset with every requester active.
    bus.req = 16'hFFFF;
    bus.din = 16'h0000;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_vld", 32'(bus.dout_vld), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_gnt", 32'(bus.gnt), 32'h0001);
    chk("first_sel", 32'(bus.sel), 32'h0);
    step(16'hFFFF, 2);
    step(16'h0000, 3);

    // Single requester 5 with a toggling data bit.
    vld_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vld_cnt += int'(bus.dout_vld);
      bus.req = (i < 5) ? 16'h0020 : 16'h0000;
      bus.din = (i % 2 == 0) ? 16'h0020 : 16'h0000;
    end
    chk("single_vld_len", 32'(vld_cnt), 32'd5);

    // Fairness: each owner drops its request after two grant cycles.
    prev_gnt = 16'h0000;
    hold_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt == prev_gnt && bus.gnt != 16'h0000) hold_cnt++;
      else hold_cnt = 1;
      prev_gnt = bus.gnt;
      r = 16'h8003;
      if (hold_cnt == 2) r = r & ~bus.gnt;
      bus.req = r;
      bus.din = 16'($urandom);
    end
    step(16'h0000, 3);

    // Wrap-around: serve 14 so the pointer lands on 15.
    step(16'h4000, 2);
    step(16'h0000, 2);
    step(16'h8001, 1);
    @(negedge clk);
    chk("wrap_gnt15", 32'(bus.gnt), 32'h8000);
    step(16'h8001, 2);
    step(16'h0001, 3);
    @(negedge clk);
    chk("wrap_gnt0", 32'(bus.gnt), 32'h0001);
    step(16'h0000, 3);

    // Two steady requesters: hold limit alternates them, else 1 keeps it.
    step(16'h0006, 20);
    step(16'h0000, 3);

    // Randomized traffic with sparse, slowly changing requests.
    r = 16'h0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      step(r, 1);
    end

    // Asynchronous reset in the middle of a grant.
    step(16'h0300, 4);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_gnt", 32'(bus.gnt), 32'h0);
    chk("arst_vld", 32'(bus.dout_vld), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    bus.req = 16'hFFFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_restart_gnt", 32'(bus.gnt), 32'h0001);
    step(16'hFFFF, 4);
    step(16'h0000, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
